// File: rtl/bit16_ddr3_wr_pkg.sv
// Shared constants and types for the 16-bit to DDR3 native write path.
package bit16_ddr3_wr_pkg;

   // Native interface command code for a write.
   localparam logic [2:0] CMD_WRITE = 3'b000;

   // One DDR3 beat is eight 16-bit words.
   localparam int BEAT_W         = 128;
   localparam int WORD_W         = 16;
   localparam int WORDS_PER_BEAT = 8;
   localparam int WCNT_W         = $clog2(WORDS_PER_BEAT);

   // Burst issue sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/bit16_ddr3_wr_burst_fifo.sv
// Small synchronous FIFO holding packed beats between the packer and the
// DDR3 issue sequencer. Pointers carry one extra wrap bit so all DEPTH slots
// are usable; DEPTH must be a power of two and at least 2.
module burst_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             push_ok;
   logic             pop_ok;

   // Status flags and guarded push/pop; pointers advance independently so a
   // simultaneous push and pop both take effect.
   always_comb begin
      empty_o    = (wr_ptr_q == rd_ptr_q);
      full_o     = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                   (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
      push_ok    = push_i && !full_o;
      pop_ok     = pop_i && !empty_o;
      wr_ptr_d   = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      pop_data_o = mem_q[rd_ptr_q[IDX_W-1:0]];
   end

   // Pointer registers; reset empties the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write port.
   // NOTE: the array has no reset; an empty FIFO never exposes its contents,
   // and leaving it unreset lets synthesis map it onto plain RAM/flops cheaply.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[IDX_W-1:0]] <= push_data_i;
      end
   end

endmodule

// File: rtl/bit16_ddr3_wr.sv
// Packs valid 16-bit words into 128-bit beats, queues them in burst_fifo and
// issues one DDR3 native write (command + single data beat) per queued beat.
module bit16_ddr3_wr
   import bit16_ddr3_wr_pkg::*;
#(
   parameter int                ADDR_W     = 28,
   parameter int                ADDR_STEP  = 8,
   parameter logic [ADDR_W-1:0] ADDR_LAST  = 28'h0FF_FFF8,
   parameter int                FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       bit16_in,
   input  logic              bit16_in_vld,
   output logic [ADDR_W-1:0] app_addr,
   output logic [2:0]        app_cmd,
   output logic              app_en,
   input  logic              app_rdy,
   output logic [127:0]      app_wdf_data,
   output logic              app_wdf_wren,
   output logic              app_wdf_end,
   input  logic              app_wdf_rdy,
   output logic [15:0]       app_wdf_mask,
   output logic              overflow,
   output logic [31:0]       burst_cnt
);

   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORDS_PER_BEAT - 1);
   localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
   localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);
   localparam int                PACK_W    = BEAT_W - WORD_W;

   // Packer state: word counter and the first seven words of the beat.
   logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
   logic [PACK_W-1:0] pack_q, pack_d;
   logic              overflow_q, overflow_d;
   logic [BEAT_W-1:0] beat;
   logic              fifo_push;

   // FIFO side.
   logic [BEAT_W-1:0] fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;

   // Issue sequencer state.
   state_e            state_q, state_d;
   logic              cmd_done_q, cmd_done_d;
   logic              data_done_q, data_done_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       burst_cnt_q, burst_cnt_d;
   logic              cmd_ok;
   logic              data_ok;

   // Packer: shift each valid word in; the eighth word completes the beat
   // straight into the FIFO, or is dropped (sticky overflow) when it is full.
   // NOTE: every variable gets a default at the top of a combinational block
   // so no path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      word_cnt_d = word_cnt_q;
      pack_d     = pack_q;
      overflow_d = overflow_q;
      fifo_push  = 1'b0;
      beat       = {pack_q, bit16_in};
      if (bit16_in_vld) begin
         if (word_cnt_q == WCNT_LAST) begin
            word_cnt_d = '0;
            if (fifo_full) begin
               overflow_d = 1'b1;
            end else begin
               fifo_push = 1'b1;
            end
         end else begin
            word_cnt_d = word_cnt_q + WCNT_ONE;
            pack_d     = {pack_q[PACK_W-WORD_W-1:0], bit16_in};
         end
      end
   end

   // Packer registers; reset also discards any partial beat.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its pre-edge inputs regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt_q <= '0;
         pack_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         word_cnt_q <= word_cnt_d;
         pack_q     <= pack_d;
         overflow_q <= overflow_d;
      end
   end

   burst_fifo #(
      .WIDTH (BEAT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (fifo_push),
      .push_data_i (beat),
      .pop_i       (fifo_pop),
      .pop_data_o  (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   // Sequencer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Sequencer next state: leave ISSUE once command and data have both been
   // accepted, whether earlier (done flag) or on this very edge.
   always_comb begin
      cmd_ok  = cmd_done_q  || (app_en && app_rdy);
      data_ok = data_done_q || (app_wdf_wren && app_wdf_rdy);
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
         ST_ISSUE: if (cmd_ok && data_ok) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Sequencer outputs: each valid stays up until its own handshake is done.
   // Data is gated to zero outside the write window; the head cannot change
   // during ISSUE because the pop only happens in DONE.
   always_comb begin
      app_en       = (state_q == ST_ISSUE) && !cmd_done_q;
      app_wdf_wren = (state_q == ST_ISSUE) && !data_done_q;
      app_wdf_end  = app_wdf_wren;
      app_wdf_data = app_wdf_wren ? fifo_head : '0;
      app_addr     = addr_q;
      app_cmd      = CMD_WRITE;
      app_wdf_mask = '0;
      fifo_pop     = (state_q == ST_DONE);
      overflow     = overflow_q;
      burst_cnt    = burst_cnt_q;
   end

   // Per-burst bookkeeping: handshake flags, address walk and burst counter.
   always_comb begin
      cmd_done_d  = (state_q == ST_ISSUE) ? cmd_ok  : 1'b0;
      data_done_d = (state_q == ST_ISSUE) ? data_ok : 1'b0;
      addr_d      = addr_q;
      burst_cnt_d = burst_cnt_q;
      if (state_q == ST_DONE) begin
         addr_d      = (addr_q == ADDR_LAST) ? '0 : addr_q + STEP;
         burst_cnt_d = burst_cnt_q + 32'd1;
      end
   end

   // Bookkeeping registers; reset abandons any burst in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_done_q  <= 1'b0;
         data_done_q <= 1'b0;
         addr_q      <= '0;
         burst_cnt_q <= '0;
      end else begin
         cmd_done_q  <= cmd_done_d;
         data_done_q <= data_done_d;
         addr_q      <= addr_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

endmodule

// File: tb/tb_bit16_ddr3_wr.sv
// Directed bench for bit16_ddr3_wr with a short wrap (ADDR_LAST = 16).
module tb_bit16_ddr3_wr;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [15:0]  bit16_in = '0;
   logic         bit16_in_vld = 1'b0;
   logic [27:0]  app_addr;
   logic [2:0]   app_cmd;
   logic         app_en;
   logic         app_rdy = 1'b0;
   logic [127:0] app_wdf_data;
   logic         app_wdf_wren;
   logic         app_wdf_end;
   logic         app_wdf_rdy = 1'b0;
   logic [15:0]  app_wdf_mask;
   logic         overflow;
   logic [31:0]  burst_cnt;

   int tests_run    = 0;
   int tests_failed = 0;

   // Monitor bookkeeping (written only by the monitor process).
   int           en_cycles   = 0;
   int           wren_cycles = 0;
   int           cmd_cnt     = 0;
   int           stab_err    = 0;
   logic [27:0]  last_addr   = '0;
   logic [127:0] last_data   = '0;
   logic         en_pend     = 1'b0;
   logic         dat_pend    = 1'b0;
   logic [27:0]  pend_addr   = '0;
   logic [127:0] pend_data   = '0;

   int base_en;
   int base_wren;
   int base_cmd;

   always #5 clk = ~clk;

   bit16_ddr3_wr #(
      .ADDR_W     (28),
      .ADDR_STEP  (8),
      .ADDR_LAST  (28'd16),
      .FIFO_DEPTH (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bit16_in     (bit16_in),
      .bit16_in_vld (bit16_in_vld),
      .app_addr     (app_addr),
      .app_cmd      (app_cmd),
      .app_en       (app_en),
      .app_rdy      (app_rdy),
      .app_wdf_data (app_wdf_data),
      .app_wdf_wren (app_wdf_wren),
      .app_wdf_end  (app_wdf_end),
      .app_wdf_rdy  (app_wdf_rdy),
      .app_wdf_mask (app_wdf_mask),
      .overflow     (overflow),
      .burst_cnt    (burst_cnt)
   );

   // Handshake monitor: counts valid cycles, records accepted address/data
   // and flags any change of address/data while a valid is held unaccepted.
   always @(posedge clk) begin
      stab_err <= stab_err
                + ((en_pend  && app_en       && (app_addr     !== pend_addr)) ? 1 : 0)
                + ((dat_pend && app_wdf_wren && (app_wdf_data !== pend_data)) ? 1 : 0);
      if (app_en) en_cycles <= en_cycles + 1;
      if (app_wdf_wren) wren_cycles <= wren_cycles + 1;
      if (app_en && app_rdy) begin
         cmd_cnt   <= cmd_cnt + 1;
         last_addr <= app_addr;
      end
      if (app_wdf_wren && app_wdf_rdy) last_data <= app_wdf_data;
      en_pend   <= app_en && !app_rdy;
      dat_pend  <= app_wdf_wren && !app_wdf_rdy;
      pend_addr <= app_addr;
      pend_data <= app_wdf_data;
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests_run++;
      assert (got === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [15:0] w, input int gap);
      bit16_in     = w;
      bit16_in_vld = 1'b1;
      tick();
      bit16_in_vld = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic wait_bursts(input int target, input int budget, input string tag);
      int n = 0;
      while (burst_cnt != 32'(target) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, burst_cnt, 128'(target));
   endtask

   task automatic wait_en(input int budget, input string tag);
      int n = 0;
      while (app_en !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(tag, app_en, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- reset state ----------------
      #23;
      check("rst_app_en",    app_en,       0);
      check("rst_wren",      app_wdf_wren, 0);
      check("rst_end",       app_wdf_end,  0);
      check("rst_addr",      app_addr,     0);
      check("rst_data",      app_wdf_data, 0);
      check("rst_burst_cnt", burst_cnt,    0);
      check("rst_overflow",  overflow,     0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // ---------------- burst 1: consecutive words, ready always ----------------
      app_rdy     = 1'b1;
      app_wdf_rdy = 1'b1;
      for (int i = 1; i <= 8; i++) send_word(16'(i), 0);
      @(negedge clk);
      check("t1_no_en_same_cycle", app_en, 0);
      @(negedge clk);
      check("t1_app_en",   app_en,       1);
      check("t1_wren",     app_wdf_wren, 1);
      check("t1_end",      app_wdf_end,  1);
      check("t1_cmd",      app_cmd,      0);
      check("t1_mask",     app_wdf_mask, 0);
      check("t1_addr",     app_addr,     0);
      check("t1_data",     app_wdf_data, 128'h0001_0002_0003_0004_0005_0006_0007_0008);
      wait_bursts(1, 20, "t1_burst_cnt");

      // ---------------- burst 2: 3-cycle gaps between words ----------------
      base_en = en_cycles;
      for (int i = 1; i <= 7; i++) send_word(16'(i), 3);
      check("t2_no_en_before_8th", en_cycles - base_en, 0);
      send_word(16'h0008, 0);
      wait_bursts(2, 20, "t2_burst_cnt");
      check("t2_addr", last_addr, 28'd8);
      check("t2_data", last_data, 128'h0001_0002_0003_0004_0005_0006_0007_0008);

      // ---------------- burst 3: command stalled 5 cycles ----------------
      app_rdy   = 1'b0;
      base_en   = en_cycles;
      base_wren = wren_cycles;
      for (int i = 1; i <= 8; i++) send_word(16'hA000 + 16'(i), 0);
      wait_en(10, "t3_en_up");
      check("t3_data", app_wdf_data, 128'hA001_A002_A003_A004_A005_A006_A007_A008);
      repeat (5) @(negedge clk);
      app_rdy = 1'b1;
      wait_bursts(3, 20, "t3_burst_cnt");
      check("t3_en_cycles",   en_cycles - base_en,     6);
      check("t3_wren_cycles", wren_cycles - base_wren, 1);
      check("t3_addr",        last_addr, 28'd16);
      check("t3_last_data",   last_data, 128'hA001_A002_A003_A004_A005_A006_A007_A008);
      base_cmd = cmd_cnt;
      repeat (10) tick();
      check("t3_single_pop_cnt", burst_cnt, 3);
      check("t3_no_extra_cmd",   cmd_cnt - base_cmd, 0);

      // ---------------- burst 4: address wraps after ADDR_LAST ----------------
      for (int i = 1; i <= 8; i++) send_word(16'h1111 * 16'(i), 0);
      wait_bursts(4, 20, "t4_burst_cnt");
      check("t4_addr_wrap", last_addr, 28'd0);
      check("t4_data",      last_data, 128'h1111_2222_3333_4444_5555_6666_7777_8888);

      // ---------------- overflow: 40 words with command blocked ----------------
      app_rdy = 1'b0;
      for (int i = 0; i < 32; i++) send_word(16'h0100 + 16'(i), 0);
      check("t5_no_overflow_at_4", overflow, 0);
      for (int i = 32; i < 40; i++) send_word(16'h0100 + 16'(i), 0);
      check("t5_overflow_set", overflow, 1);
      app_rdy = 1'b1;
      wait_bursts(8, 100, "t5_burst_cnt");
      check("t5_overflow_sticky", overflow, 1);
      check("t5_last_addr", last_addr, 28'd8);
      check("t5_last_data", last_data, 128'h0118_0119_011A_011B_011C_011D_011E_011F);
      repeat (20) tick();
      check("t5_fifth_dropped", burst_cnt, 8);

      // ---------------- reset during ISSUE with 3 beats queued ----------------
      app_rdy = 1'b0;
      for (int i = 0; i < 24; i++) send_word(16'h0200 + 16'(i), 0);
      wait_en(10, "t6_en_up");
      send_word(16'hDEAD, 0);
      send_word(16'hBEEF, 0);
      send_word(16'hCAFE, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t6_rst_en",       app_en,       0);
      check("t6_rst_wren",     app_wdf_wren, 0);
      check("t6_rst_end",      app_wdf_end,  0);
      check("t6_rst_addr",     app_addr,     0);
      check("t6_rst_data",     app_wdf_data, 0);
      check("t6_rst_cnt",      burst_cnt,    0);
      check("t6_rst_overflow", overflow,     0);
      @(negedge clk);
      rst_n   = 1'b1;
      app_rdy = 1'b1;
      base_en = en_cycles;
      repeat (20) tick();
      check("t6_quiet_after_rst", en_cycles - base_en, 0);
      for (int i = 1; i <= 8; i++) send_word(16'hC000 + 16'(i), 0);
      wait_bursts(1, 20, "t6_burst_cnt");
      check("t6_addr", last_addr, 28'd0);
      check("t6_data", last_data, 128'hC001_C002_C003_C004_C005_C006_C007_C008);

      check("stable_addr_data", stab_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/bit16_ddr3_wr.md
BIT16_DDR3_WR -- requirements
Module: bit16_ddr3_wr

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, DDR3 native address width.
REQ-002 SHALL have parameter ADDR_STEP, default 8, address increment per 128-bit burst.
REQ-003 SHALL have parameter ADDR_LAST, default 28'h0FF_FFF8, last burst address before wrap to 0.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, number of buffered 128-bit beats (power of 2).
REQ-005 clk  input  1  single clock domain for all logic.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 bit16_in  input  16  data word from the byte-to-word packer.
REQ-008 bit16_in_vld  input  1  qualifies bit16_in; no backpressure.
REQ-009 app_addr  output  ADDR_W  native write address.
REQ-010 app_cmd  output  3  native command; constant 3'b000 (write).
REQ-011 app_en  output  1  command valid.
REQ-012 app_rdy  input  1  command accepted when high with app_en.
REQ-013 app_wdf_data  output  128  write data beat.
REQ-014 app_wdf_wren  output  1  data valid.
REQ-015 app_wdf_end  output  1  last beat of burst; equal to app_wdf_wren.
REQ-016 app_wdf_rdy  input  1  data accepted when high with app_wdf_wren.
REQ-017 app_wdf_mask  output  16  constant 16'h0000.
REQ-018 overflow  output  1  sticky flag, word lost because FIFO full.
REQ-019 burst_cnt  output  32  count of completed bursts (cmd and data both accepted), wraps at 2^32.

Function
REQ-020 Packer SHALL collect 8 valid words; first word in [127:112], eighth in [15:0]; cycles without bit16_in_vld SHALL not advance the word counter.
REQ-021 On the eighth word the packed beat SHALL be written into the FIFO in the same clock edge (latency: beat visible at FIFO output one cycle after the eighth word).
REQ-022 If the FIFO is full when a beat completes, beat SHALL be dropped, overflow SHALL set and hold until reset, packer SHALL restart at word 0.
REQ-023 FSM states: IDLE, ISSUE, DONE.
REQ-024 IDLE -> ISSUE when FIFO not empty; on entry app_en and app_wdf_wren SHALL assert with app_addr = current address and app_wdf_data = FIFO head.
REQ-025 In ISSUE, app_en SHALL drop the cycle after app_en&app_rdy; app_wdf_wren SHALL drop the cycle after app_wdf_wren&app_wdf_rdy; the two handshakes are independent and may complete in either order or the same cycle.
REQ-026 ISSUE -> DONE when both handshakes completed; DONE SHALL pop FIFO, increment burst_cnt, advance address, then go to IDLE.
REQ-027 Address SHALL advance by ADDR_STEP; at ADDR_LAST next address SHALL be 0.
REQ-028 app_addr and app_wdf_data SHALL be stable while their respective valid is high.
REQ-029 Simultaneous FIFO push and pop SHALL both occur; full/empty computed with depth-inclusive pointers (no lost slot).
REQ-030 Input words SHALL be accepted in every state, including during ISSUE stalls.

Reset
REQ-031 On rst_n low (asynchronous): app_en, app_wdf_wren, app_wdf_end, overflow = 0; app_addr = 0; app_wdf_data = 0; burst_cnt = 0; FSM = IDLE; FIFO empty; word counter = 0.
REQ-032 Reset mid-burst SHALL abandon the burst and partial beat without further handshake; release SHALL be sampled synchronously.

Structure
REQ-033 Shared package SHALL hold CMD_WRITE = 3'b000, beat width 128, words per beat 8, and the FSM state enumeration.
REQ-034 FIFO SHALL be a separate sub-module burst_fifo (parameterised width/depth, push/pop/full/empty).

Verification
REQ-035 Words 16'h0001..16'h0008 consecutive, app_rdy=app_wdf_rdy=1 -> one burst, app_addr=0, app_wdf_data=128'h0001_0002_0003_0004_0005_0006_0007_0008, burst_cnt=1.
REQ-036 Same 8 words with bit16_in_vld gaps of 3 cycles -> identical beat; no app_en before eighth word.
REQ-037 app_rdy held 0 for 5 cycles, app_wdf_rdy=1 -> wren drops after 1 cycle, app_en held 6 cycles with stable addr, single pop, burst_cnt=1.
REQ-038 ADDR_LAST=16, three bursts -> app_addr 0, 8, 16, then fourth burst at 0.
REQ-039 app_rdy=0 permanently, 40 words -> 4 beats buffered, fifth dropped, overflow=1 and stays 1 after app_rdy returns; 4 bursts complete.
REQ-040 rst_n pulsed low during ISSUE with 3 beats queued -> outputs 0 immediately, no further app_en after release until 8 new words.
